rf_port_sched: RTL
==================

Name: rf_port_sched

Overview:
- Sequences and shares the register file's single write port and single read port among four sources: load return, load-immediate (r3), ALU writeback, and the CPP/CYY copy operations (src -> r1/r2).
- Sits between decode/execute/data-memory and the register file. It is the only driver of the regfile write-enable, write-address and write-data.
- Copies run as a 2-phase microsequence (read, then write). Load returns cannot be stalled, so they are absorbed by a 1-entry buffer.

Parameters:
- W, 8, data width
- A, 4, register address width
- MAX_WAIT, 3, consecutive denied ALU cycles before the ALU is promoted
- R_CPP, 1, copy destination when cpy_sel=0
- R_CYY, 2, copy destination when cpy_sel=1
- R_IMM, 3, load-immediate destination

Ports:
- Clk  in  1  clock, rising edge
- Reset  in  1  reset, synchronous, active-high
- ld_valid  in  1  load data returning this cycle (no backpressure)
- ld_addr  in  A  load destination
- ld_data  in  W  load data
- imm_req  in  1  load-immediate request
- imm_data  in  W  immediate value
- imm_gnt  out  1  immediate accepted (1-cycle pulse)
- alu_req  in  1  ALU writeback request
- alu_addr  in  A  ALU destination
- alu_data  in  W  ALU result
- alu_gnt  out  1  ALU accepted (1-cycle pulse)
- cpy_req  in  1  copy request
- cpy_sel  in  1  0 -> R_CPP, 1 -> R_CYY
- cpy_src  in  A  copy source register
- cpy_done  out  1  copy write issued (1-cycle pulse)
- rf_raddr  out  A  regfile read address
- rf_rdata  in  W  regfile combinational read data
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  A  regfile write address (registered)
- rf_wdata  out  W  regfile write data (registered)
- busy  out  1  copy FSM not idle; front end stalls
- ld_overflow  out  1  sticky: a load was dropped

Behaviour:
- Reset (sync, active-high) values:
  - state=IDLE, load buffer empty, starve counter 0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0.
  - busy=0, ld_overflow=0, all grants/cpy_done 0.
- Reset mid-copy aborts the copy: no write is issued and no cpy_done pulses.
- Requester handshake: a requester holds req and its data stable until it sees its gnt, which is combinational in cycle t. The requester may drop req at t+1.
- Write latency: a grant in cycle t registers {rf_we=1, rf_waddr, rf_wdata} at edge t+1. With no grant, rf_we=0 next cycle and addr/data hold their values.
- Load source L: the buffer entry if the buffer is occupied, else the direct ld_valid input.
- Write-port priority per cycle (exactly one winner):
  1. copy write (state CPY_WR)
  2. ALU, if starve counter == MAX_WAIT
  3. L
  4. imm
  5. ALU
- Load buffer:
  - Direct ld_valid that does not win the port is stored in the buffer.
  - If the buffer is occupied and L wins the port while ld_valid=1, the new load replaces the drained entry in the same edge.
  - If the buffer is occupied, L loses the port and ld_valid=1: the new load is dropped, the buffer is kept, and ld_overflow sets and stays set until Reset.
- Starve counter:
  - Increments when alu_req && !alu_gnt, saturating at MAX_WAIT.
  - Clears on alu_gnt or when alu_req=0.
- Copy FSM:
  - IDLE:
    - On cpy_req -> CPY_RD and latch src/dst.
    - Other writers arbitrate normally in the same cycle.
  - CPY_RD:
    - Drives rf_raddr=src.
    - Captures the hold register at the edge, then -> CPY_WR.
    - Forwarding: if rf_we=1 and rf_waddr==src in this cycle, capture rf_wdata instead of rf_rdata.
  - CPY_WR:
    - Wins the write port with waddr=dst and wdata=hold.
    - cpy_done pulses; -> IDLE.
  - busy=1 in CPY_RD and CPY_WR. cpy_req is ignored while busy.
- rf_raddr is cpy_src-latched in CPY_RD and 0 otherwise. It is registered-free: combinational from state.

Test Plan:
- Priority: imm_req=1 (0x5A) and alu_req=1 (r7, 0x11) in the same cycle -> imm_gnt; next edge rf_we=1, waddr=3, wdata=0x5A. The ALU is granted the following cycle: waddr=7, wdata=0x11.
- Load preempts the ALU: ld_valid (r4, 0xC3) with alu_req pending -> write r4=0xC3. The ALU is granted next cycle, and the starve counter returns to 0.
- Starvation with MAX_WAIT=3: ld_valid every cycle for 5 cycles plus alu_req -> the ALU is granted on its 4th requesting cycle. That cycle's load is buffered and written next cycle. ld_overflow stays 0.
- Copy with forwarding: r5=0x22. The ALU writes r5=0x99, granted the cycle before CPY_RD, and cpy_req(sel=1, src=5) is asserted -> busy=1 for 2 cycles, cpy_done pulses, and r2 is written with 0x99.
- Overflow: buffer full during CPY_WR plus a new ld_valid (r6, 0x77) -> 0x77 dropped, the buffered load is written after the copy, and ld_overflow=1 until Reset.
- Reset in CPY_RD -> next cycle busy=0, rf_we=0, no write to r1/r2, no cpy_done, ld_overflow=0.

Source files
------------

// File: rtl/rf_port_sched.sv
// rf_port_sched: owns the register file's single write port and single read
// port. Arbitrates load returns, load-immediate, ALU writeback and the
// CPP/CYY copy microsequence. Load returns cannot be stalled, so one that
// loses the port is parked in a 1-entry buffer.
module rf_port_sched #(
  parameter int W        = 8,
  parameter int A        = 4,
  parameter int MAX_WAIT = 3,
  parameter int R_CPP    = 1,
  parameter int R_CYY    = 2,
  parameter int R_IMM    = 3
) (
  input  logic         Clk,
  input  logic         Reset,
  // load return (no backpressure)
  input  logic         ld_valid,
  input  logic [A-1:0] ld_addr,
  input  logic [W-1:0] ld_data,
  // load-immediate
  input  logic         imm_req,
  input  logic [W-1:0] imm_data,
  output logic         imm_gnt,
  // ALU writeback
  input  logic         alu_req,
  input  logic [A-1:0] alu_addr,
  input  logic [W-1:0] alu_data,
  output logic         alu_gnt,
  // copy request
  input  logic         cpy_req,
  input  logic         cpy_sel,
  input  logic [A-1:0] cpy_src,
  output logic         cpy_done,
  // register file
  output logic [A-1:0] rf_raddr,
  input  logic [W-1:0] rf_rdata,
  output logic         rf_we,
  output logic [A-1:0] rf_waddr,
  output logic [W-1:0] rf_wdata,
  // status
  output logic         busy,
  output logic         ld_overflow
);

  // Starve counter only needs to reach MAX_WAIT.
  localparam int SW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_WAIT);

  localparam logic [A-1:0] ADDR_CPP = A'(R_CPP);
  localparam logic [A-1:0] ADDR_CYY = A'(R_CYY);
  localparam logic [A-1:0] ADDR_IMM = A'(R_IMM);

  // Copy microsequence states
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CPY_RD = 2'd1;
  localparam logic [1:0] CPY_WR = 2'd2;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [1:0]    state_reg, state_next;
  logic [A-1:0]  src_reg, src_next;
  logic [A-1:0]  dst_reg, dst_next;
  logic [W-1:0]  hold_reg, hold_next;

  logic          buf_valid_reg, buf_valid_next;
  logic [A-1:0]  buf_addr_reg, buf_addr_next;
  logic [W-1:0]  buf_data_reg, buf_data_next;
  logic          ovf_reg, ovf_next;

  logic [SW-1:0] starve_reg, starve_next;

  logic          rf_we_reg, rf_we_next;
  logic [A-1:0]  rf_waddr_reg, rf_waddr_next;
  logic [W-1:0]  rf_wdata_reg, rf_wdata_next;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic          l_valid;
  logic [A-1:0]  l_addr;
  logic [W-1:0]  l_data;
  logic          alu_promote;
  logic          win_cpy, win_alu, win_ld, win_imm;

  // Pick exactly one write-port winner; nothing wins while Reset is held so
  // a copy caught by reset never reports completion.
  always_comb begin
    l_valid     = buf_valid_reg | ld_valid;
    l_addr      = buf_valid_reg ? buf_addr_reg : ld_addr;
    l_data      = buf_valid_reg ? buf_data_reg : ld_data;
    alu_promote = alu_req && (starve_reg == STARVE_MAX);
    win_cpy     = 1'b0;
    win_alu     = 1'b0;
    win_ld      = 1'b0;
    win_imm     = 1'b0;
    if (!Reset) begin
      if (state_reg == CPY_WR) begin
        win_cpy = 1'b1;
      end else if (alu_promote) begin
        win_alu = 1'b1;
      end else if (l_valid) begin
        win_ld = 1'b1;
      end else if (imm_req) begin
        win_imm = 1'b1;
      end else if (alu_req) begin
        win_alu = 1'b1;
      end
    end
  end

  // Select the write the winner presents; addr/data hold when idle.
  always_comb begin
    rf_we_next    = win_cpy | win_alu | win_ld | win_imm;
    rf_waddr_next = rf_waddr_reg;
    rf_wdata_next = rf_wdata_reg;
    if (win_cpy) begin
      rf_waddr_next = dst_reg;
      rf_wdata_next = hold_reg;
    end else if (win_alu) begin
      rf_waddr_next = alu_addr;
      rf_wdata_next = alu_data;
    end else if (win_ld) begin
      rf_waddr_next = l_addr;
      rf_wdata_next = l_data;
    end else if (win_imm) begin
      rf_waddr_next = ADDR_IMM;
      rf_wdata_next = imm_data;
    end
  end

  // ---------------------------------------------------------------------
  // Load buffer: park a losing direct load, refill when the entry drains
  // in the same cycle, drop (and flag) when it is still occupied.
  // ---------------------------------------------------------------------
  // Next-state of the 1-entry load buffer and the sticky overflow flag.
  always_comb begin
    buf_valid_next = buf_valid_reg;
    buf_addr_next  = buf_addr_reg;
    buf_data_next  = buf_data_reg;
    ovf_next       = ovf_reg;
    if (buf_valid_reg) begin
      if (win_ld) begin
        if (ld_valid) begin
          buf_addr_next = ld_addr;
          buf_data_next = ld_data;
        end else begin
          buf_valid_next = 1'b0;
        end
      end else if (ld_valid) begin
        ovf_next = 1'b1;
      end
    end else if (ld_valid && !win_ld) begin
      buf_valid_next = 1'b1;
      buf_addr_next  = ld_addr;
      buf_data_next  = ld_data;
    end
  end

  // ---------------------------------------------------------------------
  // Starve counter: counts consecutive denied ALU cycles, saturating.
  // ---------------------------------------------------------------------
  // Next value of the ALU starve counter.
  always_comb begin
    if (win_alu || !alu_req) begin
      starve_next = '0;
    end else if (starve_reg != STARVE_MAX) begin
      starve_next = starve_reg + SW'(1);
    end else begin
      starve_next = starve_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Copy FSM: read src in CPY_RD (forwarding the in-flight write), then
  // write dst in CPY_WR.
  // ---------------------------------------------------------------------
  logic fwd_hit;

  // Copy sequencer next-state, including read-after-write forwarding.
  always_comb begin
    fwd_hit    = rf_we_reg && (rf_waddr_reg == src_reg);
    state_next = state_reg;
    src_next   = src_reg;
    dst_next   = dst_reg;
    hold_next  = hold_reg;
    case (state_reg)
      IDLE: begin
        if (cpy_req) begin
          state_next = CPY_RD;
          src_next   = cpy_src;
          dst_next   = cpy_sel ? ADDR_CYY : ADDR_CPP;
        end
      end
      CPY_RD: begin
        hold_next  = fwd_hit ? rf_wdata_reg : rf_rdata;
        state_next = CPY_WR;
      end
      CPY_WR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Register all state; Reset returns to idle with an empty buffer.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg     <= IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      hold_reg      <= '0;
      buf_valid_reg <= 1'b0;
      buf_addr_reg  <= '0;
      buf_data_reg  <= '0;
      ovf_reg       <= 1'b0;
      starve_reg    <= '0;
      rf_we_reg     <= 1'b0;
      rf_waddr_reg  <= '0;
      rf_wdata_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      hold_reg      <= hold_next;
      buf_valid_reg <= buf_valid_next;
      buf_addr_reg  <= buf_addr_next;
      buf_data_reg  <= buf_data_next;
      ovf_reg       <= ovf_next;
      starve_reg    <= starve_next;
      rf_we_reg     <= rf_we_next;
      rf_waddr_reg  <= rf_waddr_next;
      rf_wdata_reg  <= rf_wdata_next;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign imm_gnt     = win_imm;
  assign alu_gnt     = win_alu;
  assign cpy_done    = win_cpy;
  assign busy        = (state_reg != IDLE);
  assign rf_raddr    = (state_reg == CPY_RD) ? src_reg : '0;
  assign rf_we       = rf_we_reg;
  assign rf_waddr    = rf_waddr_reg;
  assign rf_wdata    = rf_wdata_reg;
  assign ld_overflow = ovf_reg;

endmodule
